// File: rtl/demux_1x4_pkg.sv
// Shared select encoding for the 1-to-4 demultiplexer.
package demux_1x4_pkg;

  typedef logic [1:0] sel_t;

  localparam sel_t SEL_I0 = 2'd0;
  localparam sel_t SEL_I1 = 2'd1;
  localparam sel_t SEL_I2 = 2'd2;
  localparam sel_t SEL_I3 = 2'd3;

  // Select index from the two discrete select pins, s0 being the LSB.
  function automatic sel_t make_sel(input logic s1, input logic s0);
    return {s1, s0};
  endfunction

endpackage : demux_1x4_pkg

// File: rtl/demux_1x4_decode.sv
// Combinational 2-to-4 one-hot decoder for the demux select.
module demux_1x4_decode
  import demux_1x4_pkg::*;
(
  input  sel_t       i_sel,
  output logic [3:0] o_onehot
);

  // Decode the select index into exactly one active lane.
  always_comb begin
    o_onehot = 4'b0000;
    case (i_sel)
      SEL_I0:  o_onehot = 4'b0001;
      SEL_I1:  o_onehot = 4'b0010;
      SEL_I2:  o_onehot = 4'b0100;
      SEL_I3:  o_onehot = 4'b1000;
      default: o_onehot = 4'b0000;
    endcase
  end

endmodule : demux_1x4_decode

// File: rtl/demux_1x4.sv
// 1-to-4 demultiplexer: steers Y to one of i0..i3, others forced to 0.
// Optional output register stage with asynchronous active-low reset.
module demux_1x4
  import demux_1x4_pkg::*;
#(
  parameter int DATA_W  = 1,
  parameter bit OUT_REG = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] Y,
  input  logic              s0,
  input  logic              s1,
  output logic [DATA_W-1:0] i0,
  output logic [DATA_W-1:0] i1,
  output logic [DATA_W-1:0] i2,
  output logic [DATA_W-1:0] i3
);

  sel_t              w_sel;
  logic [3:0]        w_onehot;
  logic [DATA_W-1:0] w_dec_i0;
  logic [DATA_W-1:0] w_dec_i1;
  logic [DATA_W-1:0] w_dec_i2;
  logic [DATA_W-1:0] w_dec_i3;

  assign w_sel = make_sel(s1, s0);

  demux_1x4_decode u_decode (
    .i_sel    (w_sel),
    .o_onehot (w_onehot)
  );

  // Each lane gates the full data word with its replicated one-hot bit.
  assign w_dec_i0 = Y & {DATA_W{w_onehot[0]}};
  assign w_dec_i1 = Y & {DATA_W{w_onehot[1]}};
  assign w_dec_i2 = Y & {DATA_W{w_onehot[2]}};
  assign w_dec_i3 = Y & {DATA_W{w_onehot[3]}};

  generate
    if (OUT_REG) begin : g_reg
      logic [DATA_W-1:0] r_i0;
      logic [DATA_W-1:0] r_i1;
      logic [DATA_W-1:0] r_i2;
      logic [DATA_W-1:0] r_i3;

      // All four lanes load from the same sample so only one is ever non-zero.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_i0 <= {DATA_W{1'b0}};
          r_i1 <= {DATA_W{1'b0}};
          r_i2 <= {DATA_W{1'b0}};
          r_i3 <= {DATA_W{1'b0}};
        end else begin
          r_i0 <= w_dec_i0;
          r_i1 <= w_dec_i1;
          r_i2 <= w_dec_i2;
          r_i3 <= w_dec_i3;
        end
      end

      assign i0 = r_i0;
      assign i1 = r_i1;
      assign i2 = r_i2;
      assign i3 = r_i3;
    end else begin : g_comb
      assign i0 = w_dec_i0;
      assign i1 = w_dec_i1;
      assign i2 = w_dec_i2;
      assign i3 = w_dec_i3;
    end
  endgenerate

endmodule : demux_1x4

// File: tb/tb_demux_1x4.sv
// Directed bench for demux_1x4: 1-bit and 8-bit registered instances
// sharing select pins, plus an 8-bit combinational instance.
module tb_demux_1x4;

  logic       clk;
  logic       rst_n;
  logic       s0;
  logic       s1;
  logic       y1;
  logic [7:0] y8;

  logic       a0, a1, a2, a3;
  logic [7:0] b0, b1, b2, b3;
  logic [7:0] c0, c1, c2, c3;

  int n_checks = 0;
  int n_fail   = 0;

  demux_1x4 #(.DATA_W(1), .OUT_REG(1'b1)) u_dut_w1 (
    .clk(clk), .rst_n(rst_n), .Y(y1), .s0(s0), .s1(s1),
    .i0(a0), .i1(a1), .i2(a2), .i3(a3)
  );

  demux_1x4 #(.DATA_W(8), .OUT_REG(1'b1)) u_dut_w8 (
    .clk(clk), .rst_n(rst_n), .Y(y8), .s0(s0), .s1(s1),
    .i0(b0), .i1(b1), .i2(b2), .i3(b3)
  );

  demux_1x4 #(.DATA_W(8), .OUT_REG(1'b0)) u_dut_comb (
    .clk(clk), .rst_n(rst_n), .Y(y8), .s0(s0), .s1(s1),
    .i0(c0), .i1(c1), .i2(c2), .i3(c3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [7:0] model(input logic [7:0] y, input logic [1:0] sel, input int k);
    return (sel == 2'(k)) ? y : 8'h00;
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_regs(input string tag, input logic ya, input logic [7:0] yb, input logic [1:0] sel);
    check({tag, ".w1.i0"}, {7'b0, a0}, model({7'b0, ya}, sel, 0));
    check({tag, ".w1.i1"}, {7'b0, a1}, model({7'b0, ya}, sel, 1));
    check({tag, ".w1.i2"}, {7'b0, a2}, model({7'b0, ya}, sel, 2));
    check({tag, ".w1.i3"}, {7'b0, a3}, model({7'b0, ya}, sel, 3));
    check({tag, ".w8.i0"}, b0, model(yb, sel, 0));
    check({tag, ".w8.i1"}, b1, model(yb, sel, 1));
    check({tag, ".w8.i2"}, b2, model(yb, sel, 2));
    check({tag, ".w8.i3"}, b3, model(yb, sel, 3));
  endtask

  task automatic check_comb(input string tag, input logic [7:0] yb, input logic [1:0] sel);
    check({tag, ".comb.i0"}, c0, model(yb, sel, 0));
    check({tag, ".comb.i1"}, c1, model(yb, sel, 1));
    check({tag, ".comb.i2"}, c2, model(yb, sel, 2));
    check({tag, ".comb.i3"}, c3, model(yb, sel, 3));
  endtask

  task automatic drive(input logic ya, input logic [7:0] yb, input logic [1:0] sel);
    y1 = ya;
    y8 = yb;
    s1 = sel[1];
    s0 = sel[0];
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic       vec_y1 [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
  logic [7:0] vec_y8 [8] = '{8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hFF, 8'h00, 8'h5A, 8'h3C};
  logic [1:0] vec_sel[8] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b10, 2'b01, 2'b11, 2'b00};

  initial begin
    logic       prev_y1;
    logic [7:0] prev_y8;
    logic [1:0] prev_sel;

    rst_n = 1'b1;
    drive(1'b1, 8'hA5, 2'b01);
    #2 rst_n = 1'b0;
    #1;
    check_regs("rst_async", 1'b0, 8'h00, 2'b00);
    check_comb("comb_in_rst", 8'hA5, 2'b01);
    step();
    check_regs("rst_hold", 1'b0, 8'h00, 2'b00);

    #2 rst_n = 1'b1;
    drive(1'b0, 8'h00, 2'b00);
    step();
    check_regs("first_load", 1'b0, 8'h00, 2'b00);
    prev_y1 = 1'b0; prev_y8 = 8'h00; prev_sel = 2'b00;

    for (int v = 0; v < 8; v++) begin
      drive(vec_y1[v], vec_y8[v], vec_sel[v]);
      #1;
      check_regs($sformatf("pre_edge%0d", v), prev_y1, prev_y8, prev_sel);
      check_comb($sformatf("comb%0d", v), vec_y8[v], vec_sel[v]);
      step();
      check_regs($sformatf("vec%0d", v), vec_y1[v], vec_y8[v], vec_sel[v]);
      prev_y1 = vec_y1[v]; prev_y8 = vec_y8[v]; prev_sel = vec_sel[v];
    end

    drive(1'b1, 8'hA5, 2'b11);
    step();
    check_regs("pre_midrst", 1'b1, 8'hA5, 2'b11);
    #2 rst_n = 1'b0;
    #1;
    check_regs("midrst_async", 1'b0, 8'h00, 2'b00);
    drive(1'b1, 8'hC3, 2'b10);
    step();
    check_regs("midrst_hold", 1'b0, 8'h00, 2'b00);
    #2 rst_n = 1'b1;
    #1;
    check_regs("midrst_release", 1'b0, 8'h00, 2'b00);
    step();
    check_regs("post_release", 1'b1, 8'hC3, 2'b10);

    drive(1'b1, 8'hA5, 2'b01);
    #2 {s1, s0} = 2'b10;
    #2 {s1, s0} = 2'b11;
    #2 {s1, s0} = 2'b00;
    step();
    check_regs("sel_glitch", 1'b1, 8'hA5, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_demux_1x4
